ps2_host_tx: RTL and testbench



---
 rtl/ps2_pkg.sv | 23 ++
 rtl/ps2_host_tx_if.sv | 20 ++
 rtl/ps2_line_filter.sv | 47 ++++
 rtl/ps2_host_tx.sv | 200 ++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 types, default timing and parity helper
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_SETUP,
    ST_SEND,
    ST_WAIT_ACK,
    ST_WAIT_IDLE
  } tx_state_t;

  localparam int DEF_INHIBIT_CYCLES = 5000;
  localparam int DEF_SETUP_CYCLES   = 10;
  localparam int DEF_TIMEOUT_CYCLES = 750000;
  localparam int DEF_FILTER_LEN     = 4;

  // PS/2 frames carry odd parity: the parity bit makes the total count of ones odd
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// rtl/ps2_host_tx_if.sv - byte handshake and status bundle between CPU IO logic and the transmitter
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       done;
  logic       nack;
  logic       timeout;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, busy, done, nack, timeout
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, busy, done, nack, timeout
  );
endinterface

// File: rtl/ps2_line_filter.sv
// rtl/ps2_line_filter.sv - pin synchroniser, glitch filter and falling-edge detector
module ps2_line_filter
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = DEF_FILTER_LEN
) (
  input  logic clock,
  input  logic reset,
  input  logic line,
  output logic level,
  output logic fall_edge
);

  logic                  s1;
  logic                  s2;
  logic [FILTER_LEN-1:0] hist;

  // two-flop synchroniser; idle PS/2 lines float high
  always_ff @(posedge clock) begin
    if (reset) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= line;
      s2 <= s1;
    end
  end

  // accept a new level only after FILTER_LEN identical samples; flag the 1->0 change
  always_ff @(posedge clock) begin
    if (reset) begin
      hist      <= '1;
      level     <= 1'b1;
      fall_edge <= 1'b0;
    end else begin
      hist      <= {hist[FILTER_LEN-2:0], s2};
      fall_edge <= 1'b0;
      if (&hist) begin
        level <= 1'b1;
      end else if (hist == '0) begin
        level     <= 1'b0;
        fall_edge <= level;
      end
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command byte transmitter
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
  parameter int SETUP_CYCLES   = DEF_SETUP_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int FILTER_LEN     = DEF_FILTER_LEN
) (
  input  logic         clock,
  input  logic         reset,
  ps2_host_tx_if.slave host,
  input  logic         ps2_clk_in,
  input  logic         ps2_dat_in,
  output logic         ps2_clk_drive_low,
  output logic         ps2_dat_drive_low
);

  // one shared counter times inhibit, setup and the device-clock stall window
  localparam int MAX_A     = (INHIBIT_CYCLES > SETUP_CYCLES) ? INHIBIT_CYCLES : SETUP_CYCLES;
  localparam int MAX_COUNT = (TIMEOUT_CYCLES > MAX_A) ? TIMEOUT_CYCLES : MAX_A;
  localparam int CW        = $clog2(MAX_COUNT + 1);

  localparam logic [CW-1:0] INHIBIT_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] SETUP_LAST   = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_AT   = CW'(TIMEOUT_CYCLES);

  tx_state_t     state, state_next;
  logic [CW-1:0] count, count_next;
  logic [3:0]    bit_n, bit_n_next;
  logic [7:0]    data_q, data_next;
  logic          parity_q, parity_next;
  logic          dat_low, dat_low_next;
  logic          ack_bad, ack_bad_next;
  logic          done_p, nack_p, timeout_p;

  logic          clk_level;
  logic          fall_edge;
  logic          dat_s1;
  logic          dat_sync;
  logic          stalled;

  ps2_line_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_clk_filter (
    .clock    (clock),
    .reset    (reset),
    .line     (ps2_clk_in),
    .level    (clk_level),
    .fall_edge(fall_edge)
  );

  // two-flop synchroniser for the data pin (no glitch filter needed on data)
  always_ff @(posedge clock) begin
    if (reset) begin
      dat_s1   <= 1'b1;
      dat_sync <= 1'b1;
    end else begin
      dat_s1   <= ps2_dat_in;
      dat_sync <= dat_s1;
    end
  end

  assign stalled = (count == TIMEOUT_AT);

  // state and datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ST_IDLE;
      count    <= '0;
      bit_n    <= '0;
      data_q   <= '0;
      parity_q <= 1'b0;
      dat_low  <= 1'b0;
      ack_bad  <= 1'b0;
    end else begin
      state    <= state_next;
      count    <= count_next;
      bit_n    <= bit_n_next;
      data_q   <= data_next;
      parity_q <= parity_next;
      dat_low  <= dat_low_next;
      ack_bad  <= ack_bad_next;
    end
  end

  // next-state, line control and result pulses
  always_comb begin
    state_next   = state;
    count_next   = count;
    bit_n_next   = bit_n;
    data_next    = data_q;
    parity_next  = parity_q;
    dat_low_next = dat_low;
    ack_bad_next = ack_bad;
    done_p       = 1'b0;
    nack_p       = 1'b0;
    timeout_p    = 1'b0;

    case (state)
      ST_IDLE: begin
        dat_low_next = 1'b0;
        count_next   = '0;
        if (host.tx_valid) begin
          data_next   = host.tx_data;
          parity_next = odd_parity(host.tx_data);
          state_next  = ST_INHIBIT;
        end
      end

      ST_INHIBIT: begin
        if (count == INHIBIT_LAST) begin
          count_next   = '0;
          dat_low_next = 1'b1;
          state_next   = ST_SETUP;
        end else begin
          count_next = count + CW'(1);
        end
      end

      ST_SETUP: begin
        if (count == SETUP_LAST) begin
          count_next = '0;
          bit_n_next = '0;
          state_next = ST_SEND;
        end else begin
          count_next = count + CW'(1);
        end
      end

      ST_SEND: begin
        if (fall_edge) begin
          count_next = '0;
          bit_n_next = bit_n + 4'd1;
          if (bit_n < 4'd8) begin
            dat_low_next = ~data_q[bit_n[2:0]];
          end else if (bit_n == 4'd8) begin
            dat_low_next = ~parity_q;
          end else begin
            dat_low_next = 1'b0;
            state_next   = ST_WAIT_ACK;
          end
        end else if (stalled) begin
          timeout_p    = 1'b1;
          dat_low_next = 1'b0;
          count_next   = '0;
          state_next   = ST_IDLE;
        end else begin
          count_next = count + CW'(1);
        end
      end

      ST_WAIT_ACK: begin
        if (fall_edge) begin
          ack_bad_next = dat_sync;
          count_next   = '0;
          state_next   = ST_WAIT_IDLE;
        end else if (stalled) begin
          timeout_p  = 1'b1;
          count_next = '0;
          state_next = ST_IDLE;
        end else begin
          count_next = count + CW'(1);
        end
      end

      ST_WAIT_IDLE: begin
        if (clk_level && dat_sync) begin
          done_p     = ~ack_bad;
          nack_p     = ack_bad;
          count_next = '0;
          state_next = ST_IDLE;
        end else if (stalled) begin
          timeout_p  = 1'b1;
          count_next = '0;
          state_next = ST_IDLE;
        end else begin
          count_next = count + CW'(1);
        end
      end

      default: begin
        dat_low_next = 1'b0;
        count_next   = '0;
        state_next   = ST_IDLE;
      end
    endcase
  end

  assign host.tx_ready = (state == ST_IDLE);
  assign host.busy     = (state != ST_IDLE);
  assign host.done     = done_p;
  assign host.nack     = nack_p;
  assign host.timeout  = timeout_p;

  // the start bit is still held when a stall is detected, so mask it off that same cycle
  assign ps2_clk_drive_low = (state == ST_INHIBIT) || (state == ST_SETUP);
  assign ps2_dat_drive_low = dat_low && !timeout_p;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - self-checking bench for ps2_host_tx with a PS/2 device model
module tb_ps2_host_tx;

  localparam int INHIBIT = 20;
  localparam int SETUP   = 4;
  localparam int TIMEOUT = 200;
  localparam int HALF    = 40;

  logic clock;
  logic reset;
  logic host_clk_low;
  logic host_dat_low;
  logic dev_clk_low;
  logic dev_dat_low;
  logic ps2_clk_in;
  logic ps2_dat_in;

  int checks;
  int errors;
  int done_cnt;
  int nack_cnt;
  int timeout_cnt;
  int inhibit_len;
  int setup_len;

  ps2_host_tx_if bus ();

  ps2_host_tx #(
    .INHIBIT_CYCLES(INHIBIT),
    .SETUP_CYCLES  (SETUP),
    .TIMEOUT_CYCLES(TIMEOUT),
    .FILTER_LEN    (4)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .host             (bus),
    .ps2_clk_in       (ps2_clk_in),
    .ps2_dat_in       (ps2_dat_in),
    .ps2_clk_drive_low(host_clk_low),
    .ps2_dat_drive_low(host_dat_low)
  );

  // open-drain wired-AND of host and device on each line
  assign ps2_clk_in = ~(host_clk_low | dev_clk_low);
  assign ps2_dat_in = ~(host_dat_low | dev_dat_low);

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // count result pulse cycles
  always @(negedge clock) begin
    if (bus.done)    done_cnt++;
    if (bus.nack)    nack_cnt++;
    if (bus.timeout) timeout_cnt++;
  end

  typedef struct {
    logic [7:0] data;
    bit         ack_low;
    bit         exp_parity;
    bit         exp_done;
    bit         exp_nack;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // reference frame: data LSB first, odd parity from the count of ones, stop bit 1
  function automatic logic [9:0] frame_of(input logic [7:0] d);
    int  ones;
    logic p;
    ones = $countones(d);
    p    = (ones % 2 == 0);
    return {1'b1, p, d};
  endfunction

  task automatic wait_ready(output bit ok);
    int k;
    k = 0;
    while (!bus.tx_ready && k < 1000) begin
      @(negedge clock);
      k++;
    end
    ok = bus.tx_ready;
  endtask

  task automatic handshake(input logic [7:0] d);
    bit ok;
    wait_ready(ok);
    check("accept_ready", ok, 1);
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    @(negedge clock);
    bus.tx_valid = 1'b0;
  endtask

  // device: observe request-to-send, then clock out `edges` falling edges
  task automatic run_device(input int edges, input bit ack_low, output logic [9:0] bits);
    int k;
    bits        = '0;
    inhibit_len = 0;
    setup_len   = 0;
    k = 0;
    while (!host_clk_low && k < 100) begin
      @(negedge clock);
      k++;
    end
    k = 0;
    while (host_clk_low && !host_dat_low && k < 1000) begin
      inhibit_len++;
      @(negedge clock);
      k++;
    end
    k = 0;
    while (host_clk_low && host_dat_low && k < 1000) begin
      setup_len++;
      @(negedge clock);
      k++;
    end
    repeat (HALF) @(negedge clock);
    for (int i = 0; i < edges; i++) begin
      if (i == 10) dev_dat_low = ack_low;
      dev_clk_low = 1'b1;
      repeat (HALF - 1) @(negedge clock);
      if (i < 10) bits[i] = ps2_dat_in;
      @(negedge clock);
      dev_clk_low = 1'b0;
      repeat (HALF) @(negedge clock);
      if (i == 10) dev_dat_low = 1'b0;
    end
  endtask

  task automatic transfer(input string tag, input logic [7:0] d, input bit ack_low,
                          input bit exp_done, input bit exp_nack, output logic [9:0] bits);
    int d0;
    int n0;
    int t0;
    bit ok;
    d0 = done_cnt;
    n0 = nack_cnt;
    t0 = timeout_cnt;
    handshake(d);
    run_device(11, ack_low, bits);
    wait_ready(ok);
    check({tag, "_ready"}, ok, 1);
    check({tag, "_frame"}, bits, frame_of(d));
    check({tag, "_done"}, done_cnt - d0, exp_done);
    check({tag, "_nack"}, nack_cnt - n0, exp_nack);
    check({tag, "_timeout"}, timeout_cnt - t0, 0);
  endtask

  initial begin
    vec_t       vecs[4];
    logic [9:0] bits;
    logic [7:0] d;
    bit         a;
    bit         ok;
    int         k;
    int         d0;
    int         n0;
    int         t0;

    checks = 0; errors = 0;
    done_cnt = 0; nack_cnt = 0; timeout_cnt = 0;
    dev_clk_low = 1'b0;
    dev_dat_low = 1'b0;
    bus.tx_data  = 8'h00;
    bus.tx_valid = 1'b0;
    reset = 1'b1;

    vecs[0] = '{8'hED, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{8'h01, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{8'hFF, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{8'h55, 1'b0, 1'b1, 1'b0, 1'b1};

    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    check("rst_ready", bus.tx_ready, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_pulses", {bus.done, bus.nack, bus.timeout}, 0);
    check("rst_clk_drive", host_clk_low, 0);
    check("rst_dat_drive", host_dat_low, 0);

    for (int i = 0; i < 4; i++) begin
      transfer("vec", vecs[i].data, vecs[i].ack_low, vecs[i].exp_done, vecs[i].exp_nack, bits);
      check("vec_parity", bits[8], vecs[i].exp_parity);
      if (i == 0) begin
        check("inhibit_len", inhibit_len, INHIBIT);
        check("setup_len", setup_len, SETUP);
      end
    end

    for (int r = 0; r < 6; r++) begin
      d = 8'($urandom_range(0, 255));
      a = 1'($urandom_range(0, 1));
      transfer("rand", d, a, a, !a, bits);
    end

    // device never clocks: stall detected TIMEOUT cycles after the clock is released
    d0 = done_cnt; n0 = nack_cnt; t0 = timeout_cnt;
    handshake(8'h12);
    k = 0;
    while (!host_clk_low && k < 100) begin @(negedge clock); k++; end
    k = 0;
    while (host_clk_low && k < 200) begin @(negedge clock); k++; end
    k = 0;
    while (!bus.timeout && k < 400) begin @(negedge clock); k++; end
    check("timeout_latency", k, TIMEOUT);
    check("timeout_clk_rel", host_clk_low, 0);
    check("timeout_dat_rel", host_dat_low, 0);
    @(negedge clock);
    check("timeout_idle", bus.tx_ready, 1);
    check("timeout_once", timeout_cnt - t0, 1);
    check("timeout_no_result", (done_cnt - d0) + (nack_cnt - n0), 0);

    // reset in the middle of a frame
    handshake(8'h3C);
    run_device(4, 1'b0, bits);
    check("mid_busy", bus.busy, 1);
    reset = 1'b1;
    @(negedge clock);
    check("mid_rst_clk", host_clk_low, 0);
    check("mid_rst_dat", host_dat_low, 0);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_ready", bus.tx_ready, 1);
    reset = 1'b0;
    @(negedge clock);
    transfer("after_rst", 8'hF4, 1'b1, 1'b1, 1'b0, bits);

    // byte offered while busy is ignored until ready returns
    d0 = done_cnt;
    handshake(8'h3A);
    bus.tx_data  = 8'hAA;
    bus.tx_valid = 1'b1;
    run_device(11, 1'b1, bits);
    check("busy_frame", bits, frame_of(8'h3A));
    wait_ready(ok);
    check("busy_ready", ok, 1);
    check("busy_done", done_cnt - d0, 1);
    @(negedge clock);
    bus.tx_valid = 1'b0;
    check("busy_accepted", bus.busy, 1);
    run_device(11, 1'b1, bits);
    check("held_frame", bits, frame_of(8'hAA));
    wait_ready(ok);
    check("held_ready", ok, 1);
    check("held_done", done_cnt - d0, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
